// File: rtl/ebus_seq.sv
// ebus_seq: strobe sequencer/arbiter for the shared W5300/SL811 buffered bus.
// Rev 1.0 - initial release.
`default_nettype none

module ebus_seq #(
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 3,
  parameter int T_HOLD  = 1,
  parameter int T_RECOV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_rnw,
  input  logic       req_tgt,
  input  logic [9:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       clr_ovr,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ovr,
  output logic       w5300_cs_n,
  output logic       sl811_cs_n,
  output logic [9:0] w5300_addr,
  output logic       sl811_a0,
  output logic       brd_n,
  output logic       bwr_n,
  output logic [7:0] bd_out,
  output logic       bd_oe,
  input  logic [7:0] bd_in
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RECOV  = 3'd4
  } state_t;

  localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] LD_PULSE = 4'(T_PULSE - 1);
  localparam logic [3:0] LD_HOLD  = 4'((T_HOLD > 0) ? (T_HOLD - 1) : 0);
  localparam logic [3:0] LD_RECOV = 4'(T_RECOV - 1);
  localparam logic       HAS_HOLD = (T_HOLD != 0);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic       act_rnw, act_tgt;
  logic [9:0] act_addr;
  logic [7:0] act_wdata;

  logic       pq_valid, pq_rnw, pq_tgt;
  logic [9:0] pq_addr;
  logic [7:0] pq_wdata;

  logic       direct, pop, push, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    direct     = 1'b0;
    pop        = 1'b0;
    w5300_cs_n = 1'b1;
    sl811_cs_n = 1'b1;
    brd_n      = 1'b1;
    bwr_n      = 1'b1;
    bd_oe      = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (pq_valid) begin
          pop      = 1'b1;
          state_nx = SETUP;
          cnt_nx   = LD_SETUP;
        end else if (req) begin
          direct   = 1'b1;
          state_nx = SETUP;
          cnt_nx   = LD_SETUP;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nx = STROBE;
          cnt_nx   = LD_PULSE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nx = HAS_HOLD ? HOLD : RECOV;
          cnt_nx   = HAS_HOLD ? LD_HOLD : LD_RECOV;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_nx = RECOV;
          cnt_nx   = LD_RECOV;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RECOV: begin
        if (cnt == 4'd0) begin
          // Chain straight into the queued access without an IDLE cycle.
          if (pq_valid) begin
            pop      = 1'b1;
            state_nx = SETUP;
            cnt_nx   = LD_SETUP;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase

    if (state == SETUP || state == STROBE || state == HOLD) begin
      if (act_tgt) sl811_cs_n = 1'b0;
      else         w5300_cs_n = 1'b0;
      bd_oe = ~act_rnw;
    end
    if (state == STROBE) begin
      if (act_rnw) brd_n = 1'b0;
      else         bwr_n = 1'b0;
    end
    if (state == RECOV && cnt == LD_RECOV) done = 1'b1;
  end

  // A request arriving on the edge that empties the queue takes the freed slot.
  assign push = req && !direct && (!pq_valid || pop);
  assign drop = req && !direct && pq_valid && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_rnw   <= 1'b0;
      act_tgt   <= 1'b0;
      act_addr  <= 10'd0;
      act_wdata <= 8'd0;
      pq_valid  <= 1'b0;
      pq_rnw    <= 1'b0;
      pq_tgt    <= 1'b0;
      pq_addr   <= 10'd0;
      pq_wdata  <= 8'd0;
      rdata     <= 8'd0;
      ovr       <= 1'b0;
    end else begin
      if (direct) begin
        act_rnw   <= req_rnw;
        act_tgt   <= req_tgt;
        act_addr  <= req_addr;
        act_wdata <= req_wdata;
      end else if (pop) begin
        act_rnw   <= pq_rnw;
        act_tgt   <= pq_tgt;
        act_addr  <= pq_addr;
        act_wdata <= pq_wdata;
      end

      if (push) begin
        pq_valid <= 1'b1;
        pq_rnw   <= req_rnw;
        pq_tgt   <= req_tgt;
        pq_addr  <= req_addr;
        pq_wdata <= req_wdata;
      end else if (pop) begin
        pq_valid <= 1'b0;
      end

      if (state == STROBE && cnt == 4'd0 && act_rnw) rdata <= bd_in;

      if (drop)         ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

  assign busy       = (state != IDLE) || pq_valid;
  assign w5300_addr = act_addr;
  assign sl811_a0   = act_addr[0];
  assign bd_out     = act_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ebus_seq.sv
// tb_ebus_seq: directed checks of ebus_seq timing, queueing, reset and a random soak.
`default_nettype none

module tb_ebus_seq;

  logic       clk, rst_n;
  logic       req, req_rnw, req_tgt, clr_ovr;
  logic [9:0] req_addr;
  logic [7:0] req_wdata, bd_in;

  logic       busy, done, ovr, w5300_cs_n, sl811_cs_n, sl811_a0, brd_n, bwr_n, bd_oe;
  logic [7:0] rdata, bd_out;
  logic [9:0] w5300_addr;

  logic       busy2, done2, ovr2, w5300_cs_n2, sl811_cs_n2, sl811_a02, brd_n2, bwr_n2, bd_oe2;
  logic [7:0] rdata2, bd_out2;
  logic [9:0] w5300_addr2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  ebus_seq dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rnw(req_rnw), .req_tgt(req_tgt),
    .req_addr(req_addr), .req_wdata(req_wdata), .clr_ovr(clr_ovr),
    .busy(busy), .done(done), .rdata(rdata), .ovr(ovr),
    .w5300_cs_n(w5300_cs_n), .sl811_cs_n(sl811_cs_n), .w5300_addr(w5300_addr),
    .sl811_a0(sl811_a0), .brd_n(brd_n), .bwr_n(bwr_n), .bd_out(bd_out),
    .bd_oe(bd_oe), .bd_in(bd_in)
  );

  ebus_seq #(.T_SETUP(2), .T_PULSE(1), .T_HOLD(0), .T_RECOV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rnw(req_rnw), .req_tgt(req_tgt),
    .req_addr(req_addr), .req_wdata(req_wdata), .clr_ovr(clr_ovr),
    .busy(busy2), .done(done2), .rdata(rdata2), .ovr(ovr2),
    .w5300_cs_n(w5300_cs_n2), .sl811_cs_n(sl811_cs_n2), .w5300_addr(w5300_addr2),
    .sl811_a0(sl811_a02), .brd_n(brd_n2), .bwr_n(bwr_n2), .bd_out(bd_out2),
    .bd_oe(bd_oe2), .bd_in(bd_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic rnw, input logic tgt, input logic [9:0] addr,
                         input logic [7:0] wdata);
    req       = 1'b1;
    req_rnw   = rnw;
    req_tgt   = tgt;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; req_rnw = 1'b0; req_tgt = 1'b0;
    req_addr = 10'd0; req_wdata = 8'd0; clr_ovr = 1'b0; bd_in = 8'd0;

    // Reset state
    tick(); tick();
    chk("rst.w5300_cs_n", 16'(w5300_cs_n), 16'd1);
    chk("rst.sl811_cs_n", 16'(sl811_cs_n), 16'd1);
    chk("rst.brd_n", 16'(brd_n), 16'd1);
    chk("rst.bwr_n", 16'(bwr_n), 16'd1);
    chk("rst.bd_oe", 16'(bd_oe), 16'd0);
    chk("rst.bd_out", 16'(bd_out), 16'd0);
    chk("rst.w5300_addr", 16'(w5300_addr), 16'd0);
    chk("rst.sl811_a0", 16'(sl811_a0), 16'd0);
    chk("rst.rdata", 16'(rdata), 16'd0);
    chk("rst.done", 16'(done), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.ovr", 16'(ovr), 16'd0);
    rst_n = 1'b1;
    tick();

    // 1: default W5300 read
    bd_in = 8'h5C;
    set_req(1'b1, 1'b0, 10'h2A5, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      tick();
      req = 1'b0;
      chk($sformatf("t1.w5300_cs_n c%0d", c), 16'(w5300_cs_n), 16'(!(c >= 1 && c <= 5)));
      chk($sformatf("t1.brd_n c%0d", c), 16'(brd_n), 16'(!(c >= 2 && c <= 4)));
      chk($sformatf("t1.bwr_n c%0d", c), 16'(bwr_n), 16'd1);
      chk($sformatf("t1.done c%0d", c), 16'(done), 16'(c == 6));
      chk($sformatf("t1.rdata c%0d", c), 16'(rdata), (c >= 5) ? 16'h5C : 16'h00);
      chk($sformatf("t1.sl811_cs_n c%0d", c), 16'(sl811_cs_n), 16'd1);
      chk($sformatf("t1.bd_oe c%0d", c), 16'(bd_oe), 16'd0);
      chk($sformatf("t1.w5300_addr c%0d", c), 16'(w5300_addr), 16'h2A5);
      chk($sformatf("t1.busy c%0d", c), 16'(busy), 16'(c <= 7));
    end

    // 2: SL811 write, bd_in noise must not reach rdata
    bd_in = 8'hFF;
    set_req(1'b0, 1'b1, 10'h001, 8'hA7);
    for (int c = 1; c <= 8; c++) begin
      tick();
      req = 1'b0;
      chk($sformatf("t2.sl811_cs_n c%0d", c), 16'(sl811_cs_n), 16'(!(c >= 1 && c <= 5)));
      chk($sformatf("t2.w5300_cs_n c%0d", c), 16'(w5300_cs_n), 16'd1);
      chk($sformatf("t2.bwr_n c%0d", c), 16'(bwr_n), 16'(!(c >= 2 && c <= 4)));
      chk($sformatf("t2.brd_n c%0d", c), 16'(brd_n), 16'd1);
      chk($sformatf("t2.bd_oe c%0d", c), 16'(bd_oe), 16'(c >= 1 && c <= 5));
      chk($sformatf("t2.bd_out c%0d", c), 16'(bd_out), 16'hA7);
      chk($sformatf("t2.sl811_a0 c%0d", c), 16'(sl811_a0), 16'd1);
      chk($sformatf("t2.rdata c%0d", c), 16'(rdata), 16'h5C);
      chk($sformatf("t2.done c%0d", c), 16'(done), 16'(c == 6));
    end

    // 3: queueing and overrun
    bd_in = 8'h3C;
    for (int c = 0; c <= 14; c++) begin
      if (c == 0)      set_req(1'b0, 1'b0, 10'h100, 8'h11);
      else if (c == 1) set_req(1'b1, 1'b0, 10'h0F3, 8'h00);
      else if (c == 2) set_req(1'b0, 1'b1, 10'h002, 8'h22);
      else             req = 1'b0;
      tick();
      chk($sformatf("t3.w5300_cs_n c%0d", c + 1), 16'(w5300_cs_n),
          16'(!((c + 1 <= 5) || (c + 1 >= 8 && c + 1 <= 12))));
      chk($sformatf("t3.bwr_n c%0d", c + 1), 16'(bwr_n), 16'(!(c + 1 >= 2 && c + 1 <= 4)));
      chk($sformatf("t3.brd_n c%0d", c + 1), 16'(brd_n), 16'(!(c + 1 >= 9 && c + 1 <= 11)));
      chk($sformatf("t3.done c%0d", c + 1), 16'(done), 16'(c + 1 == 6 || c + 1 == 13));
      chk($sformatf("t3.sl811_cs_n c%0d", c + 1), 16'(sl811_cs_n), 16'd1);
      chk($sformatf("t3.ovr c%0d", c + 1), 16'(ovr), 16'(c + 1 >= 3));
      chk($sformatf("t3.busy c%0d", c + 1), 16'(busy), 16'(c + 1 <= 14));
      chk($sformatf("t3.rdata c%0d", c + 1), 16'(rdata), (c + 1 >= 12) ? 16'h3C : 16'h5C);
    end
    req = 1'b0;
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t3.ovr_cleared", 16'(ovr), 16'd0);

    set_req(1'b0, 1'b0, 10'h100, 8'h33);
    tick();
    set_req(1'b0, 1'b0, 10'h101, 8'h44);
    tick();
    set_req(1'b0, 1'b0, 10'h102, 8'h55);
    clr_ovr = 1'b1;
    tick();
    req = 1'b0;
    clr_ovr = 1'b0;
    chk("t3.ovr_set_wins", 16'(ovr), 16'd1);
    for (int i = 0; i < 13; i++) tick();
    chk("t3.idle_after_pair", 16'(busy), 16'd0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t3.ovr_cleared2", 16'(ovr), 16'd0);

    // 4: short-timing instance, two queued reads
    bd_in = 8'h96;
    for (int c = 0; c <= 8; c++) begin
      if (c == 0)      set_req(1'b1, 1'b0, 10'h055, 8'h00);
      else if (c == 1) set_req(1'b1, 1'b0, 10'h0AA, 8'h00);
      else             req = 1'b0;
      tick();
      chk($sformatf("t4.w5300_cs_n c%0d", c + 1), 16'(w5300_cs_n2),
          16'(!((c + 1 <= 3) || (c + 1 >= 5 && c + 1 <= 7))));
      chk($sformatf("t4.brd_n c%0d", c + 1), 16'(brd_n2), 16'(!(c + 1 == 3 || c + 1 == 7)));
      chk($sformatf("t4.done c%0d", c + 1), 16'(done2), 16'(c + 1 == 4 || c + 1 == 8));
      chk($sformatf("t4.busy c%0d", c + 1), 16'(busy2), 16'(c + 1 <= 8));
    end
    req = 1'b0;
    chk("t4.rdata", 16'(rdata2), 16'h96);
    chk("t4.addr", 16'(w5300_addr2), 16'h0AA);
    for (int i = 0; i < 8; i++) tick();
    chk("t4.main_idle", 16'(busy), 16'd0);

    // 5: reset during STROBE of a write with a second request queued
    set_req(1'b0, 1'b1, 10'h003, 8'h5A);
    tick();
    set_req(1'b1, 1'b0, 10'h0C0, 8'h00);
    tick();
    req = 1'b0;
    tick();
    chk("t5.pre_bwr_n", 16'(bwr_n), 16'd0);
    chk("t5.pre_bd_oe", 16'(bd_oe), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t5.bwr_n", 16'(bwr_n), 16'd1);
    chk("t5.brd_n", 16'(brd_n), 16'd1);
    chk("t5.sl811_cs_n", 16'(sl811_cs_n), 16'd1);
    chk("t5.w5300_cs_n", 16'(w5300_cs_n), 16'd1);
    chk("t5.bd_oe", 16'(bd_oe), 16'd0);
    chk("t5.dut2_brd_n", 16'(brd_n2), 16'd1);
    chk("t5.dut2_cs_n", 16'(w5300_cs_n2 & sl811_cs_n2), 16'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("t5.busy c%0d", c), 16'(busy), 16'd0);
      chk($sformatf("t5.done c%0d", c), 16'(done), 16'd0);
      chk($sformatf("t5.cs_n c%0d", c), 16'(w5300_cs_n & sl811_cs_n), 16'd1);
    end

    // 6: random soak with safety invariants
    for (int i = 0; i < 400; i++) begin
      req       = 1'($urandom_range(0, 1));
      req_rnw   = 1'($urandom_range(0, 1));
      req_tgt   = 1'($urandom_range(0, 1));
      req_addr  = 10'($urandom);
      req_wdata = 8'($urandom);
      bd_in     = 8'($urandom);
      clr_ovr   = ($urandom_range(0, 15) == 0);
      tick();
      chk("t6.cs_excl", 16'(!w5300_cs_n && !sl811_cs_n), 16'd0);
      chk("t6.strobe_excl", 16'(!brd_n && !bwr_n), 16'd0);
      chk("t6.oe_on_read", 16'(bd_oe && !brd_n), 16'd0);
      chk("t6.cs_excl2", 16'(!w5300_cs_n2 && !sl811_cs_n2), 16'd0);
      chk("t6.strobe_excl2", 16'(!brd_n2 && !bwr_n2), 16'd0);
      chk("t6.oe_on_read2", 16'(bd_oe2 && !brd_n2), 16'd0);
    end
    req = 1'b0;
    clr_ovr = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ebus_seq.md
# ebus_seq

Strobe sequencer and arbiter for the shared buffered peripheral bus (`bd`, `brd_n`, `bwr_n`) that the W5300 and SL811 sit on. It accepts single-byte access requests from the Z80-side port/memory decoders and queues one request while another is in flight. It drives chip select, address and bus strobes with parameterised setup, pulse, hold and recovery times, and returns captured read data. It sits in `top` between the Z80 decode logic and the external chip pins.

## Interface
- `T_SETUP`, default 1: cycles with CS/address valid before the strobe; range 1..15.
- `T_PULSE`, default 3: cycles `brd_n`/`bwr_n` is held low; range 1..15.
- `T_HOLD`, default 1: cycles CS/address/write data are held after the strobe; range 0..15.
- `T_RECOV`, default 2: idle cycles after each access, before the next CS; range 1..15.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: request strobe, sampled every rising edge.
- `req_rnw` in 1: 1 = read, 0 = write.
- `req_tgt` in 1: 0 = W5300, 1 = SL811.
- `req_addr` in 10: W5300 address; bit 0 is the SL811 A0.
- `req_wdata` in 8: write data.
- `clr_ovr` in 1: clears `ovr`.
- `busy` out 1: FSM not IDLE, or the queue is occupied.
- `done` out 1: one-cycle pulse at the end of each access.
- `rdata` out 8: last captured read byte.
- `ovr` out 1: sticky flag; a request was dropped.
- `w5300_cs_n`, `sl811_cs_n` out 1 each: chip selects, active low.
- `w5300_addr` out 10: W5300 address pins.
- `sl811_a0` out 1: SL811 A0 pin.
- `brd_n`, `bwr_n` out 1 each: bus strobes, active low.
- `bd_out` out 8: write data driven onto `bd`.
- `bd_oe` out 1: output enable for `bd_out`.
- `bd_in` in 8: `bd` as seen from the pins.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, HOLD, RECOV. A 4-bit down-counter is loaded with `T_x - 1` on entry to each timed state.
- **Active register:** holds {rnw, tgt, addr, wdata}. Single-entry queue `pq` holds the same fields plus a valid bit.
- **Request acceptance (`req`=1 at an edge):**
  - FSM in IDLE with `pq` empty: load the active register and go to SETUP.
  - Otherwise, `pq` empty: store the request in `pq`.
  - Otherwise, `pq` full: drop the request and set `ovr`.
- **SETUP:**
  - Chip select of `tgt` is low. `w5300_addr` = addr. `sl811_a0` = addr[0].
  - For writes, `bd_oe`=1 and `bd_out` = wdata.
  - Strobes stay high.
- **STROBE:**
  - As SETUP, plus `brd_n`=0 (read) or `bwr_n`=0 (write).
  - A read samples `bd_in` into `rdata` at the edge ending the last STROBE cycle.
- **HOLD:** as SETUP, with strobes high. Skipped when `T_HOLD`=0.
- **RECOV:**
  - All chip selects and strobes are high and `bd_oe`=0.
  - `done`=1 in the first RECOV cycle only.
- **Leaving RECOV:**
  - `pq` valid: move `pq` into the active register and go to SETUP directly, with no IDLE cycle.
  - Otherwise go to IDLE.
  - A `req` on that same edge is stored in the freed `pq`. No overrun.
- **Address/data hold:** `w5300_addr`, `sl811_a0` and `bd_out` keep their last values in IDLE/RECOV. Only the chip selects and strobes return high.
- **Select exclusivity:** at most one chip select is low at any time. Both strobes are never low together.
- **`ovr`:** set wins over `clr_ovr` in the same cycle.

## Timing
- **Reset values:** cs_n = 1, `brd_n` = 1, `bwr_n` = 1, `bd_oe` = 0, `bd_out` = 0, `w5300_addr` = 0, `sl811_a0` = 0, `rdata` = 0, `done` = 0, `busy` = 0, `ovr` = 0. FSM in IDLE, `pq` empty.
- **Cycle numbering:** request accepted at edge E0.
  - SETUP occupies cycles 1..S.
  - STROBE occupies cycles S+1..S+P.
  - HOLD occupies cycles S+P+1..S+P+H.
  - `done` is high in cycle S+P+H+1.
  - Defaults: strobe low in cycles 2-4, `done` in cycle 6, next access SETUP earliest in cycle 8.
- **Read data:** `rdata` is updated at the edge ending cycle S+P and is valid from cycle S+P+1 until the next read capture. Writes never change `rdata`.
- **Write data:** `bd_oe` is high for exactly the SETUP, STROBE and HOLD cycles of a write.
- **Back-to-back accesses:** minimum CS-high gap is `T_RECOV` cycles.
- **`busy`:** is 1 from the cycle after acceptance until the IDLE state is reached with `pq` empty.
- **Reset mid-access:** asserting `rst_n` forces all outputs to their reset values immediately, without waiting for a clock edge. The in-flight access and `pq` are discarded and no `done` is produced.

## Test plan
1. **Default read:** W5300 read, addr 0x2A5, `bd_in`=0x5C, defaults.
   - `w5300_cs_n` low in cycles 1-5; `brd_n` low in cycles 2-4.
   - `done` in cycle 6; `rdata`=0x5C; `sl811_cs_n` stays 1.
2. **SL811 write:** addr[0]=1, wdata 0xA7.
   - `sl811_a0`=1, `bwr_n` low 3 cycles.
   - `bd_oe`=1 with `bd_out`=0xA7 in cycles 1-5 only; `rdata` unchanged.
3. **Queueing and overrun:** three `req` pulses in consecutive cycles.
   - The first two complete in order, the second's SETUP starting the cycle after the first's last RECOV cycle.
   - The third is dropped and `ovr`=1.
   - `clr_ovr` pulsed alone clears `ovr`; `clr_ovr` and an overrun in the same cycle leave `ovr`=1.
4. **Parameter sweep:** `T_SETUP`=2, `T_PULSE`=1, `T_HOLD`=0, `T_RECOV`=1.
   - Strobe low in cycle 3 only; `done` in cycle 4; next SETUP earliest in cycle 5.
5. **Reset mid-access:** `rst_n` low during a STROBE cycle.
   - Same timestep: all strobes and chip selects are 1 and `bd_oe`=0.
   - After release: `busy`=0, no `done`, and the queued request is gone.
6. **Random soak:** random mixed requests.
   - Both chip selects are never low together, both strobes are never low together, and `bd_oe` is never 1 during a read.
